// File: rtl/app_mac_signed.sv
// app_mac_signed
// Sequential signed multiply-accumulate stage. Operand pairs arrive on a
// valid/ready handshake and go through the signed multiplier. The products
// are summed in a saturating accumulator, and one dot-product result is
// emitted per vector. A vector ends on in_last, or when LEN terms have been
// accumulated.
//
// Build option:
//   APP_MAC_EXACT_EN  defined   -> exact signed A*B (golden model)
//                     undefined -> approximate app_mult_signed<W1>x<W2>
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        operand handshake; A, B signed operands, in_last
//   out_valid/out_ready      result handshake
//   acc_out                  signed dot-product result (ACC_W)
//   out_count                number of terms accumulated
//   overflow                 saturation occurred at least once in this vector

`ifndef APP_MAC_EXACT_EN
// Local behavioural stand-in for the approximate 8x8 signed multiplier.
// The two least significant product columns are dropped, so the product is
// the exact product rounded toward minus infinity to a multiple of 4.
module app_mult_signed8x8 (
  input  logic        [7:0]  A,
  input  logic        [7:0]  B,
  input  logic               cin,
  output logic signed [15:0] sum
);
  logic [15:0] full;

  assign full = $signed({{8{A[7]}}, A}) * $signed({{8{B[7]}}, B});
  assign sum  = $signed((full & 16'hFFFC) + {15'd0, cin});
endmodule
`endif

module app_mac_signed #(
  parameter int WIDTH1 = 8,
  parameter int WIDTH2 = 8,
  parameter int ACC_W  = 24,
  parameter int LEN    = 16,
  localparam int CW    = $clog2(LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic        [WIDTH1-1:0] A,
  input  logic        [WIDTH2-1:0] B,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] acc_out,
  output logic        [CW-1:0]    out_count,
  output logic                    overflow
);

  localparam int PW = WIDTH1 + WIDTH2;

  typedef enum logic {S_ACC = 1'b0, S_DONE = 1'b1} state_t;

  state_t                   state;
  logic signed [WIDTH1-1:0] a_p0;
  logic signed [WIDTH2-1:0] b_p0;
  logic                     last_p0;
  logic                     vld_p0;
  logic signed [ACC_W-1:0]  acc_p1;
  logic        [CW-1:0]     cnt_p1;
  logic                     ovf_p1;

  logic                     in_fire;
  logic                     close_p0;
  logic signed [PW-1:0]     prod_p0;
  logic signed [ACC_W:0]    sum_p0;
  logic                     sat_p0;

  // Clamp a one-bit-wider sum back to the accumulator range.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] v);
    if (v[ACC_W] != v[ACC_W-1])
      sat_acc = v[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      sat_acc = v[ACC_W-1:0];
  endfunction

  // The staged term closes the vector if it is marked last or fills LEN.
  assign close_p0 = last_p0 || (cnt_p1 == CW'(LEN - 1));
  // A closing term in flight blocks input so nothing lands behind it.
  assign in_ready = !rst && (state == S_ACC) && !(vld_p0 && close_p0);
  assign in_fire  = in_valid && in_ready;

`ifdef APP_MAC_EXACT_EN
  assign prod_p0 = PW'(a_p0) * PW'(b_p0);
`else
  generate
    if (WIDTH1 == 8 && WIDTH2 == 8) begin : g_fasm
      app_mult_signed8x8 u_mult (
        .A   (a_p0),
        .B   (b_p0),
        .cin (1'b0),
        .sum (prod_p0)
      );
    end else begin : g_trunc
      logic signed [PW-1:0] full_g;
      assign full_g  = PW'(a_p0) * PW'(b_p0);
      assign prod_p0 = full_g & {{(PW-2){1'b1}}, 2'b00};
    end
  endgenerate
`endif

  assign sum_p0 = (ACC_W+1)'(acc_p1) + (ACC_W+1)'(prod_p0);
  assign sat_p0 = sum_p0[ACC_W] ^ sum_p0[ACC_W-1];

  // ---- stage p0: operand capture ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_p0    <= '0;
      b_p0    <= '0;
      last_p0 <= 1'b0;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= in_fire;
      if (in_fire) begin
        a_p0    <= A;
        b_p0    <= B;
        last_p0 <= in_last;
      end
    end
  end

  // ---- stage p1: saturating accumulate and result FSM ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_ACC;
      acc_p1    <= '0;
      cnt_p1    <= '0;
      ovf_p1    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_ACC: begin
          if (vld_p0) begin
            acc_p1 <= sat_acc(sum_p0);
            cnt_p1 <= cnt_p1 + CW'(1);
            if (sat_p0) ovf_p1 <= 1'b1;
            if (close_p0) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            acc_p1    <= '0;
            cnt_p1    <= '0;
            ovf_p1    <= 1'b0;
            out_valid <= 1'b0;
            state     <= S_ACC;
          end
        end
        default: state <= S_ACC;
      endcase
    end
  end

  assign acc_out   = acc_p1;
  assign out_count = cnt_p1;
  assign overflow  = ovf_p1;

endmodule
